// File: rtl/mu0_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mu0_pkg
// Purpose  : Shared MU0 definitions: opcodes, phase-sequencer states and the
//            default shift-amount field width.
// Revision : 1.0 - initial release
// ============================================================================
package mu0_pkg;

  // Width of the shift-amount field IR[SHW-1:0]
  localparam int SHW_DEFAULT = 4;

  // Opcodes, IR[15:12]; the decoder imports the same constants
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JMI = 4'h5;
  localparam logic [3:0] OP_JEQ = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_LSL = 4'h9;
  localparam logic [3:0] OP_LSR = 4'hA;

  // Phase-sequencer states
  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC1 = 3'd1,
    S_EXEC2 = 3'd2,
    S_SHIFT = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  // True for the two accumulator shift instructions
  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_LSL) || (op == OP_LSR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mu0_shift_counter.sv
`default_nettype none
// ============================================================================
// Module   : mu0_shift_counter
// Purpose  : Remaining-shift counter. Loaded with SHAMT-1 when a multi-bit
//            shift starts, decremented once per shift cycle, flags the last.
// Revision : 1.0 - initial release
// ============================================================================
module mu0_shift_counter #(
  parameter int SHW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_load,
  input  logic [SHW-1:0] i_load_value,
  input  logic           i_dec,
  output logic [SHW-1:0] o_count,
  output logic           o_last
);

  logic [SHW-1:0] r_count;

  // Load has priority over decrement; the count saturates at zero so it can
  // never wrap even if decrement were requested while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - SHW'(1);
    end
  end

  assign o_count = r_count;
  assign o_last  = (r_count == SHW'(1));

endmodule
`default_nettype wire

// File: rtl/mu0_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mu0_phase_sequencer
// Purpose  : MU0 control FSM. Produces FETCH/EXEC1/EXEC2 phases, stretches
//            FETCH and EXEC2 on memory wait, halts on STP and expands
//            LSL/LSR into SHAMT single-bit shift cycles.
// Revision : 1.0 - initial release
// ============================================================================
module mu0_phase_sequencer
  import mu0_pkg::*;
#(
  parameter int SHW = SHW_DEFAULT
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic [3:0]     OP,
  input  logic [SHW-1:0] SHAMT,
  input  logic           MEM_READY,
  input  logic           RUN,
  output logic           FETCH,
  output logic           EXEC1,
  output logic           EXEC2,
  output logic           SHIFT_EN,
  output logic           SHIFT_LEFT,
  output logic           HALTED,
  output logic           RETIRE
);

  state_t         r_state;
  state_t         w_next_state;
  logic           r_shift_left;
  logic           w_is_shift;
  logic           w_multi_shift;
  logic           w_cnt_load;
  logic           w_cnt_dec;
  logic [SHW-1:0] w_cnt_load_value;
  logic [SHW-1:0] w_count;
  logic           w_last;

  assign w_is_shift       = is_shift_op(OP);
  assign w_multi_shift    = w_is_shift && (SHAMT > SHW'(1));
  // EXEC1 performs the first shift itself, so only SHAMT-1 remain
  assign w_cnt_load_value = SHAMT - SHW'(1);

  mu0_shift_counter #(
    .SHW (SHW)
  ) u_shift_counter (
    .clk          (CLK),
    .rst          (RESET),
    .i_load       (w_cnt_load),
    .i_load_value (w_cnt_load_value),
    .i_dec        (w_cnt_dec),
    .o_count      (w_count),
    .o_last       (w_last)
  );

  // State register; reset abandons any stall or partial shift
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Shift direction captured in EXEC1 and held through the S_SHIFT burst
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_shift_left <= 1'b0;
    end else if (r_state == S_EXEC1) begin
      r_shift_left <= (OP == OP_LSL);
    end
  end

  // Next-state decision
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH: if (MEM_READY) w_next_state = S_EXEC1;
      S_EXEC1: begin
        case (OP)
          OP_LDA, OP_ADD, OP_SUB:                 w_next_state = S_EXEC2;
          OP_STA, OP_JMP, OP_JMI, OP_JEQ, OP_LDI: w_next_state = S_FETCH;
          OP_STP:                                 w_next_state = S_HALT;
          OP_LSL, OP_LSR: w_next_state = w_multi_shift ? S_SHIFT : S_FETCH;
          default:                                w_next_state = S_FETCH;
        endcase
      end
      S_EXEC2: if (MEM_READY) w_next_state = S_FETCH;
      S_SHIFT: if (w_last) w_next_state = S_FETCH;
      S_HALT:  if (RUN) w_next_state = S_FETCH;
      default: w_next_state = S_FETCH;
    endcase
  end

  // Phase, shift and retire outputs decoded from state, OP and SHAMT
  always_comb begin
    FETCH      = (r_state == S_FETCH);
    EXEC1      = (r_state == S_EXEC1);
    EXEC2      = (r_state == S_EXEC2);
    HALTED     = (r_state == S_HALT);
    SHIFT_EN   = 1'b0;
    SHIFT_LEFT = r_shift_left;
    RETIRE     = 1'b0;
    w_cnt_load = 1'b0;
    w_cnt_dec  = 1'b0;
    case (r_state)
      S_EXEC1: begin
        // Direction must be valid in the same cycle as the first shift
        SHIFT_LEFT = (OP == OP_LSL);
        SHIFT_EN   = w_is_shift && (SHAMT != '0);
        w_cnt_load = w_multi_shift;
        RETIRE     = !((OP == OP_LDA) || (OP == OP_ADD) || (OP == OP_SUB))
                     && !w_multi_shift;
      end
      S_EXEC2: RETIRE = MEM_READY;
      S_SHIFT: begin
        SHIFT_EN  = (w_count != '0);
        w_cnt_dec = 1'b1;
        RETIRE    = w_last;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mu0_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mu0_phase_sequencer
// Purpose  : Self-checking bench for mu0_phase_sequencer: table of single
//            instructions with hand-computed lengths, plus stall, halt,
//            asynchronous-reset and random one-hot sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mu0_phase_sequencer;

  logic       CLK;
  logic       RESET;
  logic [3:0] OP;
  logic [3:0] SHAMT;
  logic       MEM_READY;
  logic       RUN;
  logic       FETCH, EXEC1, EXEC2, SHIFT_EN, SHIFT_LEFT, HALTED, RETIRE;

  int n_chk  = 0;
  int n_fail = 0;

  mu0_phase_sequencer #(.SHW(4)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .OP         (OP),
    .SHAMT      (SHAMT),
    .MEM_READY  (MEM_READY),
    .RUN        (RUN),
    .FETCH      (FETCH),
    .EXEC1      (EXEC1),
    .EXEC2      (EXEC2),
    .SHIFT_EN   (SHIFT_EN),
    .SHIFT_LEFT (SHIFT_LEFT),
    .HALTED     (HALTED),
    .RETIRE     (RETIRE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Hard stop in case a sequence never returns
  initial begin
    #300000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One instruction with MEM_READY=1, starting in FETCH at posedge+1.
  // Counts cycles up to and including the RETIRE cycle (bounded).
  task automatic run_instr(input logic [3:0] op, input logic [3:0] sh,
                           input logic exp_left,
                           output int cyc, output int shf, output int lbad,
                           output int ret, output int ex2, output int dark);
    bit done;
    OP = op; SHAMT = sh; MEM_READY = 1'b1; RUN = 1'b0;
    cyc = 0; shf = 0; lbad = 0; ret = 0; ex2 = 0; dark = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge CLK);
      cyc++;
      if (SHIFT_EN) begin
        shf++;
        if (SHIFT_LEFT !== exp_left) lbad++;
      end
      if (EXEC2) ex2++;
      if (!(FETCH || EXEC1 || EXEC2 || HALTED)) dark++;
      if (RETIRE) begin
        ret++;
        done = 1;
      end
      @(posedge CLK); #1;
    end
  endtask

  typedef struct {
    logic [3:0] op;
    logic [3:0] sh;
    logic       left;
    int         cyc;
    int         shf;
    int         ex2;
    int         dark;
  } vec_t;

  vec_t vecs [16];

  initial begin
    int cyc, shf, lbad, ret, ex2, dark;
    int nf, ne1, ne2, nret, ret_idx, nh, bad1h, nrand_ret;
    logic [7:0] pat;

    // op, shamt, left, cycles, shift cycles, exec2 cycles, S_SHIFT cycles
    vecs[0]  = '{4'h2, 4'h0, 1'b0, 3,  0,  1, 0};   // ADD
    vecs[1]  = '{4'h0, 4'h0, 1'b0, 3,  0,  1, 0};   // LDA
    vecs[2]  = '{4'h3, 4'h0, 1'b0, 3,  0,  1, 0};   // SUB
    vecs[3]  = '{4'h1, 4'h0, 1'b0, 2,  0,  0, 0};   // STA
    vecs[4]  = '{4'h4, 4'h0, 1'b0, 2,  0,  0, 0};   // JMP
    vecs[5]  = '{4'h5, 4'h0, 1'b0, 2,  0,  0, 0};   // JMI
    vecs[6]  = '{4'h6, 4'h0, 1'b0, 2,  0,  0, 0};   // JEQ
    vecs[7]  = '{4'h8, 4'h0, 1'b0, 2,  0,  0, 0};   // LDI
    vecs[8]  = '{4'hC, 4'h0, 1'b0, 2,  0,  0, 0};   // NOP
    vecs[9]  = '{4'hF, 4'h3, 1'b0, 2,  0,  0, 0};   // NOP, SHAMT ignored
    vecs[10] = '{4'h9, 4'h5, 1'b1, 6,  5,  0, 4};   // LSL 5
    vecs[11] = '{4'hA, 4'h1, 1'b0, 2,  1,  0, 0};   // LSR 1
    vecs[12] = '{4'h9, 4'h0, 1'b1, 2,  0,  0, 0};   // LSL 0
    vecs[13] = '{4'hA, 4'hF, 1'b0, 16, 15, 0, 14};  // LSR 15
    vecs[14] = '{4'h9, 4'h2, 1'b1, 3,  2,  0, 1};   // LSL 2
    vecs[15] = '{4'hB, 4'h0, 1'b0, 2,  0,  0, 0};   // NOP

    // ---------------- reset state ----------------
    RESET = 1'b1; OP = 4'h0; SHAMT = 4'h0; MEM_READY = 1'b0; RUN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_fetch",      int'(FETCH),      1);
    chk("rst_exec1",      int'(EXEC1),      0);
    chk("rst_exec2",      int'(EXEC2),      0);
    chk("rst_halted",     int'(HALTED),     0);
    chk("rst_shift_en",   int'(SHIFT_EN),   0);
    chk("rst_shift_left", int'(SHIFT_LEFT), 0);
    chk("rst_retire",     int'(RETIRE),     0);
    RESET = 1'b0;
    @(posedge CLK); #1;
    chk("fetch_hold_no_ready", int'(FETCH), 1);

    // ---------------- table of single instructions ----------------
    for (int i = 0; i < 16; i++) begin
      run_instr(vecs[i].op, vecs[i].sh, vecs[i].left, cyc, shf, lbad, ret, ex2, dark);
      chk($sformatf("vec%0d_op%0h_cycles", i, vecs[i].op),    cyc,  vecs[i].cyc);
      chk($sformatf("vec%0d_op%0h_shift_en", i, vecs[i].op),  shf,  vecs[i].shf);
      chk($sformatf("vec%0d_op%0h_shift_dir", i, vecs[i].op), lbad, 0);
      chk($sformatf("vec%0d_op%0h_retires", i, vecs[i].op),   ret,  1);
      chk($sformatf("vec%0d_op%0h_exec2", i, vecs[i].op),     ex2,  vecs[i].ex2);
      chk($sformatf("vec%0d_op%0h_shift_st", i, vecs[i].op),  dark, vecs[i].dark);
      chk($sformatf("vec%0d_op%0h_fetch_after", i, vecs[i].op), int'(FETCH), 1);
    end

    // ---------------- memory stalls: LDA, 3 in FETCH, 2 in EXEC2 ----------------
    // MEM_READY per cycle (LSB first): 0,0,0,1 | 0 (EXEC1, no effect) | 0,0,1
    pat = 8'b1000_1000;
    OP = 4'h0; SHAMT = 4'h0; RUN = 1'b0;
    nf = 0; ne1 = 0; ne2 = 0; nret = 0; ret_idx = -1;
    for (int i = 0; i < 8; i++) begin
      MEM_READY = pat[i];
      @(negedge CLK);
      if (FETCH) nf++;
      if (EXEC1) ne1++;
      if (EXEC2) ne2++;
      if (RETIRE) begin
        nret++;
        ret_idx = i;
      end
      @(posedge CLK); #1;
    end
    chk("stall_fetch_cycles", nf,  4);
    chk("stall_exec1_cycles", ne1, 1);
    chk("stall_exec2_cycles", ne2, 3);
    chk("stall_retires",      nret, 1);
    chk("stall_retire_cycle", ret_idx, 7);
    chk("stall_fetch_after",  int'(FETCH), 1);

    // ---------------- STP, halt, restart ----------------
    OP = 4'h7; SHAMT = 4'h0; MEM_READY = 1'b1; RUN = 1'b1;  // RUN ignored outside HALT
    @(negedge CLK);
    chk("stp_fetch", int'(FETCH), 1);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("stp_exec1",        int'(EXEC1),  1);
    chk("stp_exec1_retire", int'(RETIRE), 1);
    chk("stp_exec1_halted", int'(HALTED), 0);
    @(posedge CLK); #1;
    RUN = 1'b0;
    nh = 0; nf = 0;
    for (int i = 0; i < 10; i++) begin
      MEM_READY = i[0];
      @(negedge CLK);
      if (HALTED) nh++;
      if (FETCH || RETIRE) nf++;
      @(posedge CLK); #1;
    end
    chk("halt_cycles",        nh, 10);
    chk("halt_no_fetch",      nf, 0);
    MEM_READY = 1'b0;
    RUN = 1'b1;
    @(negedge CLK);
    chk("halt_run_cycle", int'(HALTED), 1);
    @(posedge CLK); #1;
    RUN = 1'b0;
    chk("restart_fetch",  int'(FETCH),  1);
    chk("restart_halted", int'(HALTED), 0);

    // ---------------- asynchronous reset during LSL 15 ----------------
    OP = 4'h9; SHAMT = 4'hF; MEM_READY = 1'b1;
    @(posedge CLK); #1;                         // now EXEC1 (1st shift)
    chk("ar_exec1_shift", int'(SHIFT_EN), 1);
    @(posedge CLK); #1;                         // S_SHIFT (2nd shift)
    @(posedge CLK); #1;                         // S_SHIFT (3rd shift)
    chk("ar_third_shift", int'(SHIFT_EN), 1);
    #2;
    RESET = 1'b1;
    #1;
    chk("ar_fetch_now",    int'(FETCH),    1);
    chk("ar_shift_en_now", int'(SHIFT_EN), 0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    MEM_READY = 1'b0;
    shf = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (SHIFT_EN) shf++;
      @(posedge CLK); #1;
    end
    chk("ar_no_more_shift", shf, 0);
    chk("ar_shift_left_clr", int'(SHIFT_LEFT), 0);
    // Fresh shift after the abandoned one starts from a clean counter
    run_instr(4'h9, 4'h3, 1'b1, cyc, shf, lbad, ret, ex2, dark);
    chk("ar_next_lsl3_cycles", cyc, 4);
    chk("ar_next_lsl3_shifts", shf, 3);

    // ---------------- random opcode run: phase one-hot ----------------
    bad1h = 0; nrand_ret = 0;
    for (int i = 0; i < 1000; i++) begin
      if (FETCH) begin
        OP    = 4'($urandom_range(0, 15));
        SHAMT = 4'($urandom_range(0, 15));
      end
      MEM_READY = ($urandom_range(0, 3) != 0);
      RUN       = ($urandom_range(0, 7) == 0);
      @(negedge CLK);
      if ((int'(FETCH) + int'(EXEC1) + int'(EXEC2) + int'(HALTED)) > 1) bad1h++;
      if (RETIRE) nrand_ret++;
      @(posedge CLK); #1;
    end
    chk("rand_onehot_violations", bad1h, 0);
    chk("rand_progress", int'(nrand_ret > 50), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
